// File: rtl/vote_streak_pkg.sv
// Shared definitions for the vote streak detector: FSM encodings and counter widths.
// Used by the RTL and the testbench alike.
package vote_streak_pkg;

    localparam int STREAK_W = 4;
    localparam int TOTAL_W  = 8;

    localparam logic [STREAK_W-1:0] STREAK_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALARM = 2'd2,
        ST_RSVD  = 2'd3
    } state_e;

endpackage : vote_streak_pkg

// File: rtl/vote_streak_detector_sat_counter.sv
// sat_counter: W-bit up counter with synchronous clear, count enable and an
// optional hold at all-ones (SATURATE=1) instead of wrapping (SATURATE=0).
module sat_counter #(
    parameter int W        = 4,
    parameter bit SATURATE = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear wins over enable; at max either hold or wrap.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            if (SATURATE && (count_q == CNT_MAX)) begin
                count_d = count_q;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/vote_streak_detector.sv
// vote_streak_detector: counts consecutive valid 1-votes and raises an alarm
// once the streak reaches THRESH. Optional lifetime 1-vote counter out_total
// is built only when the macro VOTE_STREAK_TOTAL_EN is defined.
module vote_streak_detector
    import vote_streak_pkg::*;
#(
    parameter int THRESH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_val,
    input  logic                in_vote,
    input  logic                clr,
    output logic [STREAK_W-1:0] out_streak,
    output logic                out_alarm,
    output logic [1:0]          out_state
`ifdef VOTE_STREAK_TOTAL_EN
    ,
    output logic [TOTAL_W-1:0]  out_total
`endif
);

    // Refuse to elaborate with a threshold the 4-bit streak cannot represent.
    generate
        if ((THRESH < 1) || (THRESH > 15)) begin : g_bad_thresh
            $error("vote_streak_detector: THRESH must be in 1..15");
        end
    endgenerate

    localparam logic [STREAK_W:0] THRESH_W = THRESH[STREAK_W:0];

    state_e              state_q;
    state_e              state_d;
    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W:0]   streak_inc;
    logic                vote_one;
    logic                vote_zero;
    logic                streak_clr;

    assign vote_one   = in_val &  in_vote;
    assign vote_zero  = in_val & ~in_vote;
    assign streak_inc = {1'b0, streak_q} + {{STREAK_W{1'b0}}, 1'b1};

    // A valid 0, an explicit clear or the stray encoding all drop the streak to 0,
    // keeping the counter consistent with the IDLE state the FSM moves to.
    assign streak_clr = clr | vote_zero | (state_q == ST_RSVD);

    sat_counter #(
        .W        (STREAK_W),
        .SATURATE (1'b1)
    ) u_streak (
        .clk   (clk),
        .rst   (rst),
        .clr   (streak_clr),
        .en    (vote_one),
        .count (streak_q)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: clear first, then recover the unused code, then valid samples.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else if (state_q == ST_RSVD) begin
            state_d = ST_IDLE;
        end else if (in_val) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_vote) begin
                        state_d = (THRESH == 1) ? ST_ALARM : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!in_vote) begin
                        state_d = ST_IDLE;
                    end else if (streak_inc == THRESH_W) begin
                        state_d = ST_ALARM;
                    end
                end
                ST_ALARM: begin
                    if (!in_vote) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: pure decode of registered state and streak.
    always_comb begin
        out_state  = state_q;
        out_alarm  = (state_q == ST_ALARM);
        out_streak = streak_q;
    end

`ifdef VOTE_STREAK_TOTAL_EN
    // Lifetime 1-vote count; wraps and ignores clr, only reset clears it.
    sat_counter #(
        .W        (TOTAL_W),
        .SATURATE (1'b0)
    ) u_total (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .en    (vote_one),
        .count (out_total)
    );
`endif

endmodule : vote_streak_detector

// File: tb/tb_vote_streak_detector.sv
// Testbench for vote_streak_detector (THRESH=3): a directed vector table plus
// hand-written sequences for saturation, mid-streak reset and, when
// VOTE_STREAK_TOTAL_EN is defined, the wrapping out_total counter.
module tb_vote_streak_detector;
    import vote_streak_pkg::*;

    localparam int NVEC = 18;

    typedef struct packed {
        logic       rst;
        logic       clr;
        logic       val;
        logic       vote;
        logic [3:0] streak;
        logic       alarm;
        logic [1:0] state;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_val;
    logic       in_vote;
    logic       clr;
    logic [3:0] out_streak;
    logic       out_alarm;
    logic [1:0] out_state;
`ifdef VOTE_STREAK_TOTAL_EN
    logic [7:0] out_total;
`endif

    int n_vec = 0;
    int n_bad = 0;

    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    vote_streak_detector #(.THRESH(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_val     (in_val),
        .in_vote    (in_vote),
        .clr        (clr),
        .out_streak (out_streak),
        .out_alarm  (out_alarm),
        .out_state  (out_state)
`ifdef VOTE_STREAK_TOTAL_EN
        ,
        .out_total  (out_total)
`endif
    );

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic c, input logic v, input logic vo);
        rst     = r;
        clr     = c;
        in_val  = v;
        in_vote = vo;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] e_streak,
                         input logic e_alarm, input logic [1:0] e_state);
        n_vec++;
        if (out_streak !== e_streak || out_alarm !== e_alarm || out_state !== e_state) begin
            n_bad++;
            $display("FAIL %s: got streak=%0d alarm=%0d state=%0d, want streak=%0d alarm=%0d state=%0d",
                     name, out_streak, out_alarm, out_state, e_streak, e_alarm, e_state);
        end else begin
            $display("ok   %s: streak=%0d alarm=%0d state=%0d", name, out_streak, out_alarm, out_state);
        end
    endtask

    initial begin
        // Directed table: {rst, clr, val, vote, streak, alarm, state}
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, ST_IDLE};   // reset with valid 1
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0, ST_IDLE};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, ST_RUN};    // threshold run
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, ST_RUN};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, ST_ALARM};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, ST_IDLE};   // valid 0 drops it
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, ST_RUN};    // gap pattern
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, ST_RUN};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, ST_RUN};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, ST_RUN};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0, ST_RUN};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b1, ST_ALARM};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 1'b1, ST_ALARM};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, ST_IDLE};   // clr beats valid 1 in ALARM
        vecs[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd1, 1'b0, ST_RUN};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0, ST_IDLE};   // rst with clr
        vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, ST_IDLE};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, ST_IDLE};

        rst = 1'b1; clr = 1'b0; in_val = 1'b0; in_vote = 1'b0;
        #1;

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst, vecs[i].clr, vecs[i].val, vecs[i].vote);
            check($sformatf("vec%0d", i), vecs[i].streak, vecs[i].alarm, vecs[i].state);
        end

        // Saturation: 20 valid 1s from IDLE, streak holds at 15, alarm stays up.
        begin
            int s = 0;
            for (int i = 0; i < 20; i++) begin
                step(1'b0, 1'b0, 1'b1, 1'b1);
                s = (s == 15) ? 15 : s + 1;
                check($sformatf("sat%0d", i), 4'(s), (s >= 3), (s >= 3) ? ST_ALARM : ST_RUN);
            end
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("sat_drop", 4'd0, 1'b0, ST_IDLE);

        // clr with in_val=0 in RUN, then reset mid-streak discards everything.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("run2", 4'd2, 1'b0, ST_RUN);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("clr_run", 4'd0, 1'b0, ST_IDLE);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        check("rst_mid", 4'd0, 1'b0, ST_IDLE);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("after_rst", 4'd1, 1'b0, ST_RUN);

`ifdef VOTE_STREAK_TOTAL_EN
        // 257 valid 1s with a clr pulse after every 16th: total wraps to 1.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (out_total !== 8'd0) begin
            n_bad++;
            $display("FAIL total_rst: got %0d want 0", out_total);
        end else begin
            $display("ok   total_rst: total=%0d", out_total);
        end
        for (int i = 1; i <= 257; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b1);
            if (i % 16 == 0) step(1'b0, 1'b1, 1'b0, 1'b0);
            if (i == 255 || i == 256 || i == 257) begin
                n_vec++;
                if (out_total !== 8'(i)) begin
                    n_bad++;
                    $display("FAIL total%0d: got %0d want %0d", i, out_total, i % 256);
                end else begin
                    $display("ok   total%0d: total=%0d", i, out_total);
                end
            end
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_vote_streak_detector

// File: doc/vote_streak_detector.md
VOTE_STREAK_DETECTOR -- requirements
Module: vote_streak_detector

Interface
REQ-001 Parameter THRESH, default 3, is the number of consecutive 1-votes that raises the alarm; it SHALL be legal only in the range 1..15.
REQ-002 Port clk input 1: the single clock; all state SHALL update on the rising edge.
REQ-003 Port rst input 1: reset, synchronous and active-high.
REQ-004 Port in_val input 1: the sample on in_vote is valid this cycle.
REQ-005 Port in_vote input 1: pair/triple detector result, 1 = at least two of three inputs high.
REQ-006 Port clr input 1: synchronous clear of streak and alarm.
REQ-007 Port out_streak output 4: current count of consecutive valid 1-votes, saturating.
REQ-008 Port out_alarm output 1: high while the streak is at or above THRESH.
REQ-009 Port out_state output 2: current FSM state encoding, for debug and verification.
REQ-010 Port out_total output 8: total accepted 1-votes; present only when the configuration macro is defined.

Function
REQ-011 The block SHALL sample in_vote only in cycles where in_val=1; cycles with in_val=0 SHALL leave all state unchanged.
REQ-012 All outputs SHALL be registered: the effect of a sample at edge N SHALL be visible after edge N, with 1-cycle latency.
REQ-013 The FSM SHALL have states IDLE=0 (streak 0), RUN=1 (1 <= streak < THRESH) and ALARM=2; encoding 3 is unused and SHALL return to IDLE on the next edge.
REQ-014 In IDLE, a valid 1 SHALL set streak to 1 and go to RUN, or go directly to ALARM when THRESH=1; a valid 0 SHALL stay in IDLE.
REQ-015 In RUN, a valid 1 SHALL increment streak and go to ALARM when the new streak equals THRESH; a valid 0 SHALL zero streak and go to IDLE.
REQ-016 In ALARM, a valid 1 SHALL increment streak, saturating at 15, and stay in ALARM; a valid 0 SHALL zero streak and go to IDLE.
REQ-017 out_alarm SHALL equal (state==ALARM).
REQ-018 When clr=1, streak SHALL become 0 and state IDLE next cycle regardless of in_val and in_vote; clr SHALL have priority over a simultaneous valid sample.
REQ-019 clr SHALL NOT modify out_total.
REQ-020 out_streak SHALL never wrap: at 15, further valid 1s SHALL hold it at 15.

Reset
REQ-021 While rst=1 at a rising edge, the next state SHALL be IDLE, with out_streak=0, out_alarm=0, out_state=0 and out_total=0.
REQ-022 rst SHALL have priority over clr and over any valid sample.
REQ-023 Reset asserted mid-streak or in ALARM SHALL discard the streak completely.

Configuration
REQ-024 Macro VOTE_STREAK_TOTAL_EN SHALL control the out_total feature.
REQ-025 With VOTE_STREAK_TOTAL_EN defined: port out_total SHALL exist and increment on each valid 1-vote, wrapping from 255 to 0.
REQ-026 Without VOTE_STREAK_TOTAL_EN: port out_total and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 State encodings IDLE/RUN/ALARM and the streak width (4) SHALL be defined in a shared header, vote_streak_pkg, included by both RTL and bench.
REQ-028 The streak SHALL be implemented in one sub-module, sat_counter, a 4-bit counter with clear, enable and saturate-at-max.
REQ-029 The optional out_total counter SHALL reuse the same sub-module style with saturation disabled.

Verification
REQ-030 Reset: hold rst=1 for 2 cycles with in_val=1 and in_vote=1 -> out_streak=0, out_alarm=0, out_state=0.
REQ-031 Threshold (THRESH=3): three consecutive valid 1s -> out_streak 1,2,3 and out_alarm rising after the third edge; a subsequent valid 0 -> out_streak=0, state IDLE.
REQ-032 Gaps: pattern 1, in_val=0 for 3 cycles, 1, 1 -> alarm after the final edge, with streak unchanged during the gap cycles.
REQ-033 Saturation: 20 consecutive valid 1s -> out_streak holds at 15 and out_alarm stays 1.
REQ-034 Priority: clr=1 together with a valid 1 while in ALARM -> next cycle streak=0, state IDLE; rst together with clr -> reset values.
REQ-035 With VOTE_STREAK_TOTAL_EN: 257 valid 1s interleaved with clr pulses -> out_total=1 (wrapped), unaffected by clr.
